// File: rtl/adder_result_checker.sv
// Checks {a, b, cin, sum, cout} records by recomputing a+b+cin CHUNK bits per cycle
// and comparing the golden {cout,sum} with the recorded result; keeps pass/error statistics.
module adder_result_checker #(
  parameter int WIDTH = 65,
  parameter int CHUNK = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]    a_q, b_q, gold_q;
  logic             carry_q;
  logic [WIDTH-1:0] cap_sum_q;
  logic             cap_cout_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] pass_q, err_q, idx_q, fidx_q;
  logic             fvld_q;

  logic [CHUNK:0]      chunk_sum;
  logic [PW+CHUNK-1:0] gold_cat;
  logic                match;

  // Operands shift right one chunk per CALC cycle; result chunks enter gold_q from the top,
  // so after NCHUNK cycles gold_q holds the zero-padded sum in natural bit order.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign gold_cat  = {chunk_sum[CHUNK-1:0], gold_q};

  // Padding bits above WIDTH are zero, so {carry, gold} equals the full sum and the golden
  // cout is its bit WIDTH; comparing the whole padded word against the zero-extended record
  // is therefore the same as comparing {cout,sum}.
  assign match = ({carry_q, gold_q} == (PW + 1)'({cap_cout_q, cap_sum_q}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Handshake: a record transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is high only in IDLE, res_valid is a single-cycle pulse in CMP.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    res_pass  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CALC;
      end
      S_CALC: begin
        if (k_q == K_LAST) state_d = S_CMP;
      end
      S_CMP: begin
        res_valid = 1'b1;
        res_pass  = match;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      gold_q     <= '0;
      carry_q    <= 1'b0;
      cap_sum_q  <= '0;
      cap_cout_q <= 1'b0;
      k_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= PW'(in_a);
            b_q        <= PW'(in_b);
            carry_q    <= in_cin;
            cap_sum_q  <= in_sum;
            cap_cout_q <= in_cout;
            k_q        <= '0;
          end
        end
        S_CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          gold_q  <= gold_cat[PW+CHUNK-1:CHUNK];
          carry_q <= chunk_sum[CHUNK];
          k_q     <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // clear outranks the CMP update, so a record completing in the clear cycle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= '0;
      err_q  <= '0;
      idx_q  <= '0;
      fvld_q <= 1'b0;
      fidx_q <= '0;
    end else if (clear) begin
      pass_q <= '0;
      err_q  <= '0;
      idx_q  <= '0;
      fvld_q <= 1'b0;
      fidx_q <= '0;
    end else if (state_q == S_CMP) begin
      if (match) begin
        if (pass_q != '1) pass_q <= pass_q + 1'b1;
      end else begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (!fvld_q) begin
          fvld_q <= 1'b1;
          fidx_q <= idx_q;
        end
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  assign pass_count    = pass_q;
  assign err_count     = err_q;
  assign first_err_vld = fvld_q;
  assign first_err_idx = fidx_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: vector table plus hand sequences for back-to-back,
// reset mid-record and clear timing; a second instance covers the single-chunk case.
module tb_adder_result_checker;

  localparam int WIDTH  = 65;
  localparam int CHUNK  = 16;
  localparam int CNT_W  = 32;
  localparam int NCHUNK = 5;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_cin, in_cout;
  logic [WIDTH-1:0] in_a, in_b, in_sum;
  logic             in_ready, res_valid, res_pass, first_err_vld;
  logic [CNT_W-1:0] pass_count, err_count, first_err_idx;
  logic [1:0]       dbg_state;

  logic             valid1, clear1, ready1, res_valid1, res_pass1, fvld1;
  logic [CNT_W-1:0] pass1, err1, fidx1;
  logic [1:0]       dbg1;

  adder_result_checker #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
    .res_valid(res_valid), .res_pass(res_pass), .pass_count(pass_count),
    .err_count(err_count), .first_err_vld(first_err_vld), .first_err_idx(first_err_idx),
    .dbg_state(dbg_state)
  );

  adder_result_checker #(.WIDTH(WIDTH), .CHUNK(65), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .in_valid(valid1), .in_ready(ready1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
    .res_valid(res_valid1), .res_pass(res_pass1), .pass_count(pass1),
    .err_count(err1), .first_err_vld(fvld1), .first_err_idx(fidx1),
    .dbg_state(dbg1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             pass;
  } rec_t;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  int m_pass = 0, m_err = 0, m_idx = 0, m_fidx = 0;
  bit m_fvld = 0;

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd65();
    return {1'($urandom_range(0, 1)), $urandom, $urandom};
  endfunction

  function automatic logic golden_pass(input rec_t r);
    logic [WIDTH:0] g;
    g = {1'b0, r.a} + {1'b0, r.b} + (WIDTH + 1)'(r.cin);
    return ({r.cout, r.sum} == g);
  endfunction

  function automatic rec_t good_rec();
    rec_t r;
    logic [WIDTH:0] g;
    r.a = rnd65();
    r.b = rnd65();
    r.cin = 1'($urandom_range(0, 1));
    g = {1'b0, r.a} + {1'b0, r.b} + (WIDTH + 1)'(r.cin);
    r.sum = g[WIDTH-1:0];
    r.cout = g[WIDTH];
    r.pass = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_pass = 0; m_err = 0; m_idx = 0; m_fidx = 0; m_fvld = 0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  int  lat = 0;
  bit  track = 0;

  always @(negedge clk) begin
    if (rst) begin
      track = 0;
      lat = 0;
    end else begin
      if (track) lat++;
      if (track && lat >= 1 && lat <= NCHUNK + 1) check("busy_in_ready", CNT_W'(in_ready), '0);
      if (res_valid) begin
        check("latency", CNT_W'(lat), CNT_W'(NCHUNK + 1));
        track = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid: got 1 expected 0");
        end else begin
          check("res_pass", CNT_W'(res_pass), CNT_W'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        track = 1;
        lat = 0;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send(input rec_t r, input bit hold);
    int g = 0;
    in_a = r.a; in_b = r.b; in_cin = r.cin; in_sum = r.sum; in_cout = r.cout;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("accept_timeout", CNT_W'(in_ready), CNT_W'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(r.pass);
    if (r.pass) m_pass++;
    else begin
      m_err++;
      if (!m_fvld) begin
        m_fvld = 1;
        m_fidx = m_idx;
      end
    end
    m_idx++;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_left", CNT_W'(exp_q.size()), '0);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pass_count"}, pass_count, CNT_W'(m_pass));
    check({tag, "_err_count"}, err_count, CNT_W'(m_err));
    check({tag, "_first_err_vld"}, CNT_W'(first_err_vld), CNT_W'(m_fvld));
    if (m_fvld) check({tag, "_first_err_idx"}, first_err_idx, CNT_W'(m_fidx));
  endtask

  // ---------------- test ----------------
  rec_t vec[7];
  rec_t r;

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] top;
    int g;
    ones = '1;
    top  = '0;
    top[WIDTH-1] = 1'b1;

    vec[0] = '{a: '0,          b: '0,       cin: 1'b0, sum: '0,           cout: 1'b0, pass: 1'b1};
    vec[1] = '{a: ones,        b: '0,       cin: 1'b1, sum: '0,           cout: 1'b1, pass: 1'b1};
    vec[2] = '{a: 65'd1,       b: 65'd1,    cin: 1'b0, sum: 65'd3,        cout: 1'b0, pass: 1'b0};
    vec[3] = '{a: ones,        b: ones,     cin: 1'b1, sum: ones,         cout: 1'b1, pass: 1'b1};
    vec[4] = '{a: 65'hFFFF,    b: 65'd1,    cin: 1'b0, sum: 65'h10000,    cout: 1'b0, pass: 1'b1};
    vec[5] = '{a: top,         b: top,      cin: 1'b0, sum: '0,           cout: 1'b1, pass: 1'b1};
    vec[6] = '{a: ones,        b: 65'd1,    cin: 1'b0, sum: '0,           cout: 1'b0, pass: 1'b0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; valid1 = 1'b0; clear1 = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0; in_cout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", CNT_W'(in_ready), CNT_W'(1));
    check("rst_res_valid", CNT_W'(res_valid), '0);
    check("rst_res_pass", CNT_W'(res_pass), '0);
    check("rst_pass_count", pass_count, '0);
    check("rst_err_count", err_count, '0);
    check("rst_first_err_vld", CNT_W'(first_err_vld), '0);
    check("rst_first_err_idx", first_err_idx, '0);
    check("rst_ready1", CNT_W'(ready1), CNT_W'(1));
    rst = 1'b0;
    @(negedge clk);

    // Vector table, one record at a time.
    for (int i = 0; i < 7; i++) begin
      send(vec[i], 1'b0);
      drain();
      if (i == 0) check("t1_pass_count", pass_count, CNT_W'(1));
      if (i == 2) begin
        check("t3_err_count", err_count, CNT_W'(1));
        check("t3_first_err_vld", CNT_W'(first_err_vld), CNT_W'(1));
        check("t3_first_err_idx", first_err_idx, CNT_W'(2));
      end
    end
    check("tab_pass_count", pass_count, CNT_W'(5));
    check("tab_err_count", err_count, CNT_W'(2));
    check("tab_first_err_idx", first_err_idx, CNT_W'(2));

    // Ten records back-to-back, records 4 and 7 corrupted.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check("clr_pass_count", pass_count, '0);
    check("clr_first_err_vld", CNT_W'(first_err_vld), '0);
    for (int i = 0; i < 10; i++) begin
      r = good_rec();
      if (i == 4 || i == 7) r.sum = r.sum ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      r.pass = golden_pass(r);
      send(r, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    check("b2b_pass_count", pass_count, CNT_W'(8));
    check("b2b_err_count", err_count, CNT_W'(2));
    check("b2b_first_err_idx", first_err_idx, CNT_W'(4));
    check_model("b2b");

    // Reset two cycles into CALC abandons the record.
    send(good_rec(), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_in_ready", CNT_W'(in_ready), CNT_W'(1));
    check("rstmid_pass_count", pass_count, '0);
    check("rstmid_err_count", err_count, '0);
    check("rstmid_first_err_vld", CNT_W'(first_err_vld), '0);
    repeat (8) @(negedge clk);
    send(good_rec(), 1'b0);
    drain();
    check("rstmid_after_pass", pass_count, CNT_W'(1));

    // clear during CALC: the in-flight failing record still counts afterwards.
    r = vec[2];
    send(r, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drain();
    check("clrcalc_pass_count", pass_count, '0);
    check("clrcalc_err_count", err_count, CNT_W'(1));
    check("clrcalc_first_err_vld", CNT_W'(first_err_vld), CNT_W'(1));
    check("clrcalc_first_err_idx", first_err_idx, '0);

    // clear in the CMP cycle of a failing record: not counted, pulse still seen.
    r = vec[6];
    send(r, 1'b0);
    g = 0;
    while (!res_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("clrcmp_res_valid", CNT_W'(res_valid), CNT_W'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("clrcmp_err_count", err_count, '0);
    check("clrcmp_pass_count", pass_count, '0);
    check("clrcmp_first_err_vld", CNT_W'(first_err_vld), '0);
    check("clrcmp_queue", CNT_W'(exp_q.size()), '0);

    // Single-chunk instance: passing record, then clear in CMP of a failing one.
    in_a = ones; in_b = '0; in_cin = 1'b1; in_sum = '0; in_cout = 1'b1;
    valid1 = 1'b1;
    check("n1_ready", CNT_W'(ready1), CNT_W'(1));
    @(negedge clk);
    valid1 = 1'b0;
    check("n1_lat1_res_valid", CNT_W'(res_valid1), '0);
    @(negedge clk);
    check("n1_lat2_res_valid", CNT_W'(res_valid1), CNT_W'(1));
    check("n1_lat2_res_pass", CNT_W'(res_pass1), CNT_W'(1));
    @(negedge clk);
    check("n1_pass_count", pass1, CNT_W'(1));

    in_a = 65'd1; in_b = 65'd1; in_cin = 1'b0; in_sum = 65'd3; in_cout = 1'b0;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    @(negedge clk);
    check("n1_bad_res_valid", CNT_W'(res_valid1), CNT_W'(1));
    check("n1_bad_res_pass", CNT_W'(res_pass1), '0);
    clear1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b0;
    check("n1_clr_err_count", err1, '0);
    check("n1_clr_pass_count", pass1, '0);
    check("n1_clr_first_err_vld", CNT_W'(fvld1), '0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
